// File: rtl/quant_mcu_scheduler.sv
// quant_mcu_scheduler
// Walks the blocks of one MCU in order: Y_PER_MCU luma blocks, then Cb, then Cr.
// Each 64-beat DCT block is forwarded from its source stream to the quantizer.
// The scheduler then waits until the quantizer has emitted the last beat of that
// block before it starts the next one. This keeps the table select (is_luma)
// stable for the entire time the block is inside the quantizer.
module quant_mcu_scheduler #(
  parameter int Y_PER_MCU = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] y_tdata,
  input  logic        y_tvalid,
  input  logic        y_tlast,
  input  logic        y_tuser,
  output logic        y_tready,
  input  logic [15:0] cb_tdata,
  input  logic        cb_tvalid,
  input  logic        cb_tlast,
  input  logic        cb_tuser,
  output logic        cb_tready,
  input  logic [15:0] cr_tdata,
  input  logic        cr_tvalid,
  input  logic        cr_tlast,
  input  logic        cr_tuser,
  output logic        cr_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        is_luma,
  input  logic        q_tvalid,
  input  logic        q_tready,
  input  logic        q_tlast,
  output logic        busy,
  output logic [15:0] mcu_count,
  output logic        err_len
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_Q} state_t;

  // Component index: 0..Y_PER_MCU-1 are luma, then Cb, then Cr
  localparam logic [2:0] CB_IDX = 3'(Y_PER_MCU);
  localparam logic [2:0] CR_IDX = 3'(Y_PER_MCU + 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  comp;
  logic [5:0]  beat;
  logic [15:0] src_tdata;
  logic        src_tvalid;
  logic        src_tlast;
  logic        src_tuser;
  logic        hs;
  logic        last_beat;
  logic        q_done;
  logic        first_beat_of_mcu;

  assign hs                = m_axis_tvalid & m_axis_tready;
  assign last_beat         = (beat == 6'd63);
  assign q_done            = q_tvalid & q_tready & q_tlast;
  assign first_beat_of_mcu = (comp == 3'd0) && (beat == 6'd0);
  assign busy              = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; quantizer completions only matter while waiting on one
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = STREAM;
      STREAM:  if (hs && last_beat) state_nxt = WAIT_Q;
      WAIT_Q:  if (q_done) state_nxt = (comp == CR_IDX) ? IDLE : STREAM;
      default: state_nxt = IDLE;
    endcase
  end

  // Source mux and handshake routing; only the selected source sees tready while streaming
  always_comb begin
    src_tdata  = y_tdata;
    src_tvalid = y_tvalid;
    src_tlast  = y_tlast;
    src_tuser  = y_tuser;
    if (comp == CB_IDX) begin
      src_tdata  = cb_tdata;
      src_tvalid = cb_tvalid;
      src_tlast  = cb_tlast;
      src_tuser  = cb_tuser;
    end else if (comp == CR_IDX) begin
      src_tdata  = cr_tdata;
      src_tvalid = cr_tvalid;
      src_tlast  = cr_tlast;
      src_tuser  = cr_tuser;
    end
    y_tready      = 1'b0;
    cb_tready     = 1'b0;
    cr_tready     = 1'b0;
    m_axis_tdata  = src_tdata;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = last_beat;
    m_axis_tuser  = 1'b0;
    if (state == STREAM) begin
      m_axis_tvalid = src_tvalid;
      m_axis_tuser  = src_tuser & first_beat_of_mcu;
      if (comp < CB_IDX)       y_tready  = m_axis_tready;
      else if (comp == CB_IDX) cb_tready = m_axis_tready;
      else                     cr_tready = m_axis_tready;
    end
  end

  // Component, beat counter and table select; is_luma moves only when a block boundary is crossed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp    <= 3'd0;
      beat    <= 6'd0;
      is_luma <= 1'b1;
    end else begin
      if (state == IDLE && enable) begin
        comp    <= 3'd0;
        beat    <= 6'd0;
        is_luma <= 1'b1;
      end else if (state == WAIT_Q && q_done) begin
        beat <= 6'd0;
        if (comp == CR_IDX) begin
          comp    <= 3'd0;
          is_luma <= 1'b1;
        end else begin
          comp    <= comp + 3'd1;
          is_luma <= ((comp + 3'd1) < CB_IDX);
        end
      end else if (hs) begin
        beat <= beat + 6'd1;
      end
    end
  end

  // MCU counter: a frame-start marker on the first beat of an MCU wins over the end-of-MCU increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_count <= 16'd0;
    end else if (hs && first_beat_of_mcu && src_tuser) begin
      mcu_count <= 16'd0;
    end else if (state == WAIT_Q && q_done && comp == CR_IDX) begin
      mcu_count <= mcu_count + 16'd1;
    end
  end

  // Sticky length error: source tlast disagrees with the scheduler's own beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_len <= 1'b0;
    else if (hs && (src_tlast != last_beat)) err_len <= 1'b1;
  end

endmodule

// File: tb/tb_quant_mcu_scheduler.sv
// tb_quant_mcu_scheduler
// Directed scenarios for the MCU scheduler. A background model drives the three
// source streams from per-source counters and plays the quantizer. It also keeps
// the expected block order and data, and counts deviations. Each test task then
// compares those tallies and the DUT outputs against hand-computed values.
module tb_quant_mcu_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] y_tdata, cb_tdata, cr_tdata;
  logic        y_tvalid, y_tlast, y_tuser, y_tready;
  logic        cb_tvalid, cb_tlast, cb_tuser, cb_tready;
  logic        cr_tvalid, cr_tlast, cr_tuser, cr_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic        is_luma;
  logic        q_tvalid, q_tready, q_tlast;
  logic        busy;
  logic [15:0] mcu_count;
  logic        err_len;

  quant_mcu_scheduler #(.Y_PER_MCU(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tlast(y_tlast), .y_tuser(y_tuser), .y_tready(y_tready),
    .cb_tdata(cb_tdata), .cb_tvalid(cb_tvalid), .cb_tlast(cb_tlast), .cb_tuser(cb_tuser), .cb_tready(cb_tready),
    .cr_tdata(cr_tdata), .cr_tvalid(cr_tvalid), .cr_tlast(cr_tlast), .cr_tuser(cr_tuser), .cr_tready(cr_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .is_luma(is_luma), .q_tvalid(q_tvalid), .q_tready(q_tready), .q_tlast(q_tlast),
    .busy(busy), .mcu_count(mcu_count), .err_len(err_len)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Controls written by the test sequence, read by the model
  bit rand_ready  = 1'b0;
  bit drive_tuser = 1'b0;
  bit bad_cb      = 1'b0;
  int cr_q_delay  = 2;
  int clear_req   = 0;

  // Model state and tallies, written only by the model process
  int clear_ack = 0;
  int y_seq, cb_seq, cr_seq;
  int exp_y, exp_cb, exp_cr;
  int out_blk, out_beat, total_beats, blocks_done;
  int data_errs, last_errs, luma_errs, wait_errs, tuser_hits, tuser_errs;
  int cr_wait, q_timer, wait_blk, mcu_after_clear;
  bit waiting, q_fire, clear_pending;
  logic [5:0] luma_seq;

  // Source/quantizer model: sample at the falling edge, update drives just after the rising edge
  initial begin : model
    logic [15:0] exp_d;
    y_tdata = 16'h1000; cb_tdata = 16'h2000; cr_tdata = 16'h3000;
    y_tlast = 1'b0; cb_tlast = 1'b0; cr_tlast = 1'b0;
    y_tuser = 1'b0; cb_tuser = 1'b0; cr_tuser = 1'b0;
    m_axis_tready = 1'b1;
    q_tvalid = 1'b0; q_tready = 1'b0; q_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (clear_req != clear_ack) begin
        clear_ack = clear_req;
        y_seq = 0; cb_seq = 0; cr_seq = 0; exp_y = 0; exp_cb = 0; exp_cr = 0;
        out_blk = 0; out_beat = 0; total_beats = 0; blocks_done = 0;
        data_errs = 0; last_errs = 0; luma_errs = 0; wait_errs = 0; tuser_hits = 0; tuser_errs = 0;
        cr_wait = 0; q_timer = 0; wait_blk = 0; mcu_after_clear = -1;
        waiting = 1'b0; q_fire = 1'b0; clear_pending = 1'b0; luma_seq = 6'd0;
      end
      if (rst_n) begin
        if (clear_pending) begin
          mcu_after_clear = int'(mcu_count);
          clear_pending = 1'b0;
        end
        if (waiting) begin
          if (y_tready || cb_tready || cr_tready || m_axis_tvalid) wait_errs++;
          if (is_luma !== (wait_blk < 4)) wait_errs++;
          if (wait_blk == 5) cr_wait++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (out_blk < 4)       begin exp_d = 16'h1000 + 16'(exp_y);  exp_y++;  end
          else if (out_blk == 4) begin exp_d = 16'h2000 + 16'(exp_cb); exp_cb++; end
          else                   begin exp_d = 16'h3000 + 16'(exp_cr); exp_cr++; end
          if (m_axis_tdata !== exp_d) data_errs++;
          if (m_axis_tlast !== (out_beat == 63)) last_errs++;
          if (is_luma !== (out_blk < 4)) luma_errs++;
          if (m_axis_tuser) begin
            tuser_hits++;
            if (!(out_blk == 0 && out_beat == 0)) tuser_errs++;
          end
          if (out_blk == 0 && out_beat == 0 && y_tuser) clear_pending = 1'b1;
          out_beat++;
          total_beats++;
          if (out_beat == 64) begin
            out_beat = 0;
            blocks_done++;
            luma_seq[out_blk] = is_luma;
            wait_blk = out_blk;
            waiting = 1'b1;
            q_timer = (out_blk == 5) ? cr_q_delay : 2;
            out_blk = (out_blk == 5) ? 0 : out_blk + 1;
          end
        end
        if (y_tvalid && y_tready)   y_seq++;
        if (cb_tvalid && cb_tready) cb_seq++;
        if (cr_tvalid && cr_tready) cr_seq++;
      end
      @(posedge clk);
      #1;
      if (q_fire) begin
        q_fire = 1'b0;
        waiting = 1'b0;
      end else if (waiting) begin
        if (q_timer == 0) q_fire = 1'b1;
        else q_timer--;
      end
      q_tvalid = q_fire; q_tready = q_fire; q_tlast = q_fire;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      y_tdata  = 16'h1000 + 16'(y_seq);
      cb_tdata = 16'h2000 + 16'(cb_seq);
      cr_tdata = 16'h3000 + 16'(cr_seq);
      y_tlast  = ((y_seq % 64) == 63);
      cb_tlast = bad_cb ? ((cb_seq % 64) == 40) : ((cb_seq % 64) == 63);
      cr_tlast = ((cr_seq % 64) == 63);
      y_tuser  = drive_tuser && ((y_seq % 64) == 0);
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_model();
    clear_req++;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic run_mcu(output bit ok);
    int n;
    @(posedge clk); #2;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(posedge clk); #2; n++; end
    enable = 1'b0;
    n = 0;
    while (busy && n < 4000) begin @(posedge clk); #2; n++; end
    ok = !busy;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
    checks++; if (mcu_count !== 16'd0) $display("[TB] FAIL reset_mcu_count: got %0d expected 0", mcu_count); else passes++;
    checks++; if (err_len !== 1'b0) $display("[TB] FAIL reset_err_len: got %0b expected 0", err_len); else passes++;
    checks++; if (is_luma !== 1'b1) $display("[TB] FAIL reset_is_luma: got %0b expected 1", is_luma); else passes++;
    checks++; if ({y_tready, cb_tready, cr_tready} !== 3'b000) $display("[TB] FAIL reset_treadys: got %b expected 000", {y_tready, cb_tready, cr_tready}); else passes++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); else passes++;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_single_mcu();
    bit ok;
    clear_model();
    run_mcu(ok);
    checks++; if (!ok) $display("[TB] FAIL single_done: busy got %0b expected 0", busy); else passes++;
    checks++; if (blocks_done !== 6) $display("[TB] FAIL single_blocks: got %0d expected 6", blocks_done); else passes++;
    checks++; if (total_beats !== 384) $display("[TB] FAIL single_beats: got %0d expected 384", total_beats); else passes++;
    checks++; if (data_errs !== 0) $display("[TB] FAIL single_data: got %0d bad beats expected 0", data_errs); else passes++;
    checks++; if (last_errs !== 0) $display("[TB] FAIL single_tlast: got %0d bad beats expected 0", last_errs); else passes++;
    checks++; if (luma_seq !== 6'b001111) $display("[TB] FAIL single_luma_order: got %b expected 001111", luma_seq); else passes++;
    checks++; if (luma_errs !== 0) $display("[TB] FAIL single_luma_beats: got %0d expected 0", luma_errs); else passes++;
    checks++; if (wait_errs !== 0) $display("[TB] FAIL single_wait: got %0d expected 0", wait_errs); else passes++;
    checks++; if (tuser_hits !== 0) $display("[TB] FAIL single_tuser: got %0d expected 0", tuser_hits); else passes++;
    checks++; if (mcu_count !== 16'd1) $display("[TB] FAIL single_mcu_count: got %0d expected 1", mcu_count); else passes++;
    checks++; if (err_len !== 1'b0) $display("[TB] FAIL single_err_len: got %0b expected 0", err_len); else passes++;
  endtask

  task automatic test_random_ready();
    bit ok;
    clear_model();
    rand_ready = 1'b1;
    run_mcu(ok);
    rand_ready = 1'b0;
    checks++; if (!ok) $display("[TB] FAIL random_done: busy got %0b expected 0", busy); else passes++;
    checks++; if (total_beats !== 384) $display("[TB] FAIL random_beats: got %0d expected 384", total_beats); else passes++;
    checks++; if (data_errs !== 0) $display("[TB] FAIL random_data: got %0d bad beats expected 0", data_errs); else passes++;
    checks++; if (last_errs !== 0) $display("[TB] FAIL random_tlast: got %0d bad beats expected 0", last_errs); else passes++;
    checks++; if (mcu_count !== 16'd2) $display("[TB] FAIL random_mcu_count: got %0d expected 2", mcu_count); else passes++;
  endtask

  task automatic test_tuser_clear();
    bit ok;
    for (int i = 0; i < 3; i++) run_mcu(ok);
    checks++; if (mcu_count !== 16'd5) $display("[TB] FAIL tuser_pre_count: got %0d expected 5", mcu_count); else passes++;
    clear_model();
    drive_tuser = 1'b1;
    run_mcu(ok);
    drive_tuser = 1'b0;
    checks++; if (!ok) $display("[TB] FAIL tuser_done: busy got %0b expected 0", busy); else passes++;
    checks++; if (mcu_after_clear !== 0) $display("[TB] FAIL tuser_cleared: got %0d expected 0", mcu_after_clear); else passes++;
    checks++; if (mcu_count !== 16'd1) $display("[TB] FAIL tuser_post_count: got %0d expected 1", mcu_count); else passes++;
    checks++; if (tuser_hits !== 1) $display("[TB] FAIL tuser_hits: got %0d expected 1", tuser_hits); else passes++;
    checks++; if (tuser_errs !== 0) $display("[TB] FAIL tuser_position: got %0d expected 0", tuser_errs); else passes++;
  endtask

  task automatic test_err_len();
    bit ok;
    clear_model();
    bad_cb = 1'b1;
    run_mcu(ok);
    bad_cb = 1'b0;
    checks++; if (err_len !== 1'b1) $display("[TB] FAIL err_set: got %0b expected 1", err_len); else passes++;
    checks++; if (total_beats !== 384) $display("[TB] FAIL err_beats: got %0d expected 384", total_beats); else passes++;
    checks++; if (last_errs !== 0) $display("[TB] FAIL err_tlast: got %0d bad beats expected 0", last_errs); else passes++;
    checks++; if (data_errs !== 0) $display("[TB] FAIL err_data: got %0d bad beats expected 0", data_errs); else passes++;
    clear_model();
    run_mcu(ok);
    checks++; if (err_len !== 1'b1) $display("[TB] FAIL err_sticky: got %0b expected 1", err_len); else passes++;
    checks++; if (mcu_count !== 16'd3) $display("[TB] FAIL err_mcu_count: got %0d expected 3", mcu_count); else passes++;
  endtask

  task automatic test_delayed_q();
    bit ok;
    clear_model();
    cr_q_delay = 200;
    run_mcu(ok);
    cr_q_delay = 2;
    checks++; if (!ok) $display("[TB] FAIL delay_done: busy got %0b expected 0", busy); else passes++;
    checks++; if (cr_wait < 200) $display("[TB] FAIL delay_cr_wait: got %0d cycles expected at least 200", cr_wait); else passes++;
    checks++; if (wait_errs !== 0) $display("[TB] FAIL delay_wait_outputs: got %0d expected 0", wait_errs); else passes++;
    checks++; if (luma_seq !== 6'b001111) $display("[TB] FAIL delay_luma_order: got %b expected 001111", luma_seq); else passes++;
    checks++; if (mcu_count !== 16'd4) $display("[TB] FAIL delay_mcu_count: got %0d expected 4", mcu_count); else passes++;
  endtask

  task automatic test_reset_mid_block();
    bit ok;
    int n;
    clear_model();
    enable = 1'b1;
    @(posedge clk); #2;
    enable = 1'b0;
    n = 0;
    while (!(out_blk == 2 && out_beat == 30) && n < 1000) begin @(posedge clk); #2; n++; end
    checks++; if (n >= 1000) $display("[TB] FAIL midrst_reach: got timeout expected Y2 beat 30"); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); else passes++;
    checks++; if ({y_tready, cb_tready, cr_tready} !== 3'b000) $display("[TB] FAIL midrst_treadys: got %b expected 000", {y_tready, cb_tready, cr_tready}); else passes++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL midrst_tvalid: got %0b expected 0", m_axis_tvalid); else passes++;
    checks++; if (is_luma !== 1'b1) $display("[TB] FAIL midrst_is_luma: got %0b expected 1", is_luma); else passes++;
    checks++; if (mcu_count !== 16'd0) $display("[TB] FAIL midrst_mcu_count: got %0d expected 0", mcu_count); else passes++;
    checks++; if (err_len !== 1'b0) $display("[TB] FAIL midrst_err_len: got %0b expected 0", err_len); else passes++;
    repeat (3) @(posedge clk);
    clear_model();
    rst_n = 1'b1;
    clear_model();
    run_mcu(ok);
    checks++; if (!ok) $display("[TB] FAIL restart_done: busy got %0b expected 0", busy); else passes++;
    checks++; if (total_beats !== 384) $display("[TB] FAIL restart_beats: got %0d expected 384", total_beats); else passes++;
    checks++; if (data_errs !== 0) $display("[TB] FAIL restart_data: got %0d bad beats expected 0", data_errs); else passes++;
    checks++; if (luma_seq !== 6'b001111) $display("[TB] FAIL restart_luma_order: got %b expected 001111", luma_seq); else passes++;
    checks++; if (mcu_count !== 16'd1) $display("[TB] FAIL restart_mcu_count: got %0d expected 1", mcu_count); else passes++;
  endtask

  // Test sequence
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    y_tvalid = 1'b1;
    cb_tvalid = 1'b1;
    cr_tvalid = 1'b1;
    test_reset();
    test_single_mcu();
    test_random_ready();
    test_tuser_clear();
    test_err_len();
    test_delayed_q();
    test_reset_mid_block();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/quant_mcu_scheduler.md
QUANT_MCU_SCHEDULER -- requirements
Module: quant_mcu_scheduler

Interface
REQ-001 SHALL have parameter Y_PER_MCU, default 4, meaning luma blocks per MCU (4 = 4:2:0, 2 = 4:2:2, 1 = 4:4:4).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  permits start of a new MCU
- y_tdata/y_tvalid/y_tlast/y_tuser  in  16/1/1/1  luma DCT block stream
- y_tready  out  1
- cb_tdata/cb_tvalid/cb_tlast/cb_tuser  in  16/1/1/1  Cb block stream
- cb_tready  out  1
- cr_tdata/cr_tvalid/cr_tlast/cr_tuser  in  16/1/1/1  Cr block stream
- cr_tready  out  1
- m_axis_tdata/m_axis_tvalid/m_axis_tlast/m_axis_tuser  out  16/1/1/1  to quantizer input
- m_axis_tready  in  1  from quantizer
- is_luma  out  1  quantizer table select
- q_tvalid/q_tready/q_tlast  in  1/1/1  snoop of quantizer output handshake
- busy  out  1  high when not IDLE
- mcu_count  out  16  MCUs completed since last frame start
- err_len  out  1  sticky block-length error

Function
REQ-003 SHALL implement states IDLE, STREAM, WAIT_Q.
REQ-004 IDLE -> STREAM when enable=1; component index set to Y block 0; otherwise remain.
REQ-005 MCU order SHALL be Y x Y_PER_MCU, then Cb, then Cr; one 64-beat block per STREAM visit.
REQ-006 In STREAM: m_axis_tdata/tvalid/tuser SHALL combinationally follow the selected source; selected source tready = m_axis_tready; unselected treadys = 0; in IDLE/WAIT_Q all treadys and m_axis_tvalid = 0.
REQ-007 6-bit beat counter SHALL increment on each m_axis handshake and reset to 0 on entry to STREAM.
REQ-008 m_axis_tlast SHALL equal (beat==63), independent of source tlast.
REQ-009 STREAM -> WAIT_Q on handshake at beat 63.
REQ-010 WAIT_Q exits on q_tvalid & q_tready & q_tlast: to STREAM with next component, or to IDLE after Cr.
REQ-011 is_luma SHALL be registered, =1 for Y blocks and =0 for Cb/Cr, and change only on the WAIT_Q exit edge (or IDLE->STREAM), so it is stable from first input beat until last quantizer output beat of each block.
REQ-012 m_axis_tuser SHALL pass source tuser only on beat 0 of Y block 0; 0 otherwise.
REQ-013 A handshake carrying y_tuser=1 at beat 0 of Y block 0 SHALL clear mcu_count to 0; if coincident with an increment, clear wins.
REQ-014 mcu_count SHALL increment (wrapping 0xFFFF->0) on WAIT_Q exit after Cr.
REQ-015 err_len SHALL set when an accepted beat has source tlast != (beat==63); cleared only by reset.
REQ-016 enable deasserted mid-MCU SHALL have no effect until the MCU completes and the FSM returns to IDLE.
REQ-017 Quantizer snoop completions observed in IDLE or STREAM SHALL be ignored.
REQ-018 Latency SHALL be zero cycles from source to m_axis in STREAM; one cycle from WAIT_Q exit condition to next STREAM.

Reset
REQ-019 While rst_n=0: state IDLE, beat=0, component=Y0, is_luma=1, busy=0, mcu_count=0, err_len=0, all treadys=0, m_axis_tvalid=0.
REQ-020 Reset asserted mid-block SHALL abandon the block immediately; no partial-block recovery.

Verification
REQ-021 Scenarios the bench SHALL cover:
- enable=1, Y_PER_MCU=4, all sources always valid, quantizer model -> 6 blocks Y,Y,Y,Y,Cb,Cr of 64 beats each; is_luma 1,1,1,1,0,0; mcu_count=1; return to IDLE.
- m_axis_tready toggling 50% random -> no beat lost/duplicated; m_axis_tlast only on 64th beat of each block.
- Y0 first beat with y_tuser=1 after mcu_count=5 -> mcu_count=0 then 1 after Cr; m_axis_tuser high on that single beat only.
- cb_tlast asserted at beat 40 -> err_len=1 sticky; block still runs 64 beats.
- delay q_tlast 200 cycles after Cr input -> is_luma stays 0, all treadys 0 during WAIT_Q.
- rst_n low at beat 30 of Y2 -> all outputs at reset values asynchronously; next enable restarts at Y0.
